// File: rtl/a0_uart_tx.sv
// Watches the core debug byte and queues every change in a small FIFO.
// Each queued byte is sent as an 8N1 UART frame on tx_o.
module a0_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [1:0]                    state_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_q, rd_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] last_q;
    logic                  ovf_q;

    logic push, pop, full, accept, last_baud;

    // A push into a full FIFO still fits when the transmitter frees a slot at the same edge.
    assign push   = (data_i != last_q);
    assign pop    = (state_q == IDLE) && (count_q != '0);
    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign accept = push && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) last_q <= data_i;
            if (push && !accept) ovf_q <= 1'b1;
            if (accept) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && accept) mem_q[wr_q] <= data_i;
    end

    assign last_baud = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    shift_d = mem_q[rd_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (last_baud) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (last_baud) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (last_baud) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level is precomputed from the next state so tx_o comes straight off a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != IDLE) || (count_q != '0);
    assign overflow_o   = ovf_q;
    assign fifo_count_o = count_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx: timestamp-based frame model plus a UART receiver on tx_o.
module tb_a0_uart_tx;
    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       tx_o, busy_o, overflow_o;
    logic [2:0] fifo_count_o;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    a0_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .tx_o(tx_o), .busy_o(busy_o),
        .overflow_o(overflow_o), .fifo_count_o(fifo_count_o), .state_o(state_o)
    );

    int cmp_n = 0;
    int err_n = 0;

    // Model: edge counter, start edge of the current frame, pending bytes.
    int         e = 0;
    int         p = -100000;
    logic [7:0] last_m = 8'h00;
    logic [7:0] cur_m = 8'h00;
    logic       ovf_m = 1'b0;
    logic [7:0] fifo_m[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    logic       rx_busy = 1'b0;
    int         rx_t0 = 0;
    logic [7:0] rx_byte = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_frame(input int ee);
        return (ee >= p) && (ee < p + 10 * C);
    endfunction

    task automatic step(input logic [7:0] d, input logic r);
        logic exp_tx;
        int   k;
        int   off;
        @(negedge clk);
        data_i = d;
        rst_i  = r;
        @(posedge clk);
        e++;
        if (r) begin
            last_m = 8'h00;
            fifo_m.delete();
            p       = -100000;
            ovf_m   = 1'b0;
            rx_busy = 1'b0;
        end else begin
            if (!in_frame(e - 1) && fifo_m.size() > 0) begin
                cur_m = fifo_m.pop_front();
                p     = e;
                exp_q.push_back(cur_m);
            end
            if (d != last_m) begin
                last_m = d;
                if (fifo_m.size() < D) fifo_m.push_back(d);
                else                   ovf_m = 1'b1;
            end
        end
        #1;
        exp_tx = 1'b1;
        if (in_frame(e)) begin
            k = (e - p) / C;
            if (k == 0)      exp_tx = 1'b0;
            else if (k <= 8) exp_tx = cur_m[k-1];
        end
        chk("tx", 32'(tx_o), 32'(exp_tx));
        chk("busy", 32'(busy_o), 32'(in_frame(e) || fifo_m.size() > 0));
        chk("count", 32'(fifo_count_o), 32'(fifo_m.size()));
        chk("ovf", 32'(overflow_o), 32'(ovf_m));
        if (!r) begin
            if (!rx_busy) begin
                if (tx_o == 1'b0) begin
                    rx_busy = 1'b1;
                    rx_t0   = e;
                end
            end else begin
                off = e - rx_t0;
                if (off % C == C / 2) begin
                    k = off / C;
                    if (k >= 1 && k <= 8) rx_byte[k-1] = tx_o;
                    else if (k == 9) begin
                        chk("stop_bit", 32'(tx_o), 32'd1);
                        rx_q.push_back(rx_byte);
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drain(input logic [7:0] d);
        int n;
        n = 0;
        step(d, 1'b0);
        while (busy_o && n < 2000) begin
            step(d, 1'b0);
            n++;
        end
        step(d, 1'b0);
        chk("drain_done", 32'(busy_o), 32'd0);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] want[$]);
        chk({tag, "_frames"}, 32'(rx_q.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < rx_q.size(); i++)
            chk({tag, "_byte"}, 32'(rx_q[i]), 32'(want[i]));
    endtask

    task automatic clear_logs();
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] base;
        logic [7:0] want[$];
        logic [7:0] v;
        int         n;

        // Reset, then a held 0x00 must never produce a frame.
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_count", 32'(fifo_count_o), 32'd0);
        for (int i = 0; i < 100; i++) step(8'h00, 1'b0);
        chk("zero_no_frame", 32'(rx_q.size()), 32'd0);

        // Single frame 0xA5: start bit from the edge after the push.
        step(8'hA5, 1'b0);
        step(8'hA5, 1'b0);
        chk("a5_start_low", 32'(tx_o), 32'd0);
        drain(8'hA5);
        want = '{8'hA5};
        check_rx("a5", want);
        clear_logs();

        // Three back-to-back changes.
        step(8'h01, 1'b0);
        step(8'h02, 1'b0);
        step(8'h03, 1'b0);
        drain(8'h03);
        want = '{8'h01, 8'h02, 8'h03};
        check_rx("seq3", want);
        chk("seq3_ovf", 32'(overflow_o), 32'd0);
        clear_logs();

        // Six distinct changes in a row: five fit, the sixth is dropped.
        step(8'h00, 1'b1);
        base = 8'($urandom_range(1, 200));
        for (int i = 0; i < 6; i++) step(base + 8'(i), 1'b0);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        drain(base + 8'd5);
        want = '{base, base + 8'd1, base + 8'd2, base + 8'd3, base + 8'd4};
        check_rx("ovf", want);
        for (int i = 0; i < 20; i++) step(8'($urandom), 1'b0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        drain(data_i);
        clear_logs();

        // Full FIFO: pop and push at the same edge keep the count at 4.
        step(8'h00, 1'b1);
        step(8'h41, 1'b0);
        for (int i = 2; i <= 5; i++) step(8'h40 + 8'(i), 1'b0);
        chk("full_count", 32'(fifo_count_o), 32'd4);
        n = 0;
        while (e != p + 10 * C && n < 100) begin
            step(8'h45, 1'b0);
            n++;
        end
        chk("full_reach_idle", 32'(n < 100), 32'd1);
        step(8'h46, 1'b0);
        chk("full_pp_count", 32'(fifo_count_o), 32'd4);
        chk("full_pp_ovf", 32'(overflow_o), 32'd0);
        drain(8'h46);
        want = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        check_rx("full", want);
        clear_logs();

        // Reset in the middle of 0x3C with two bytes queued.
        step(8'h00, 1'b1);
        step(8'h3C, 1'b0);
        step(8'h11, 1'b0);
        step(8'h22, 1'b0);
        chk("mid_count", 32'(fifo_count_o), 32'd2);
        for (int i = 0; i < C + 6; i++) step(8'h22, 1'b0);
        chk("mid_in_data", 32'(state_o), 32'd2);
        step(8'h00, 1'b1);
        chk("mid_rst_tx", 32'(tx_o), 32'd1);
        chk("mid_rst_count", 32'(fifo_count_o), 32'd0);
        rx_q.delete();
        for (int i = 0; i < 80; i++) step(8'h00, 1'b0);
        chk("mid_no_frames", 32'(rx_q.size()), 32'd0);
        drain(8'h7E);
        want = '{8'h7E};
        check_rx("after_rst", want);
        clear_logs();

        // Random traffic scored against the model's frame order.
        step(8'h00, 1'b1);
        v = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) v = 8'($urandom);
            step(v, 1'b0);
        end
        drain(v);
        check_rx("rand", exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
